// File: rtl/argo_chan_fifo.sv
// Single-clock channel FIFO for Argo pipes/channels.
// Read side is either registered (FWFT=0) or first-word-fall-through (FWFT=1).
// Occupancy, almost-full/almost-empty and status flags are all registered.
// Overflow and underflow are sticky error flags.
module argo_chan_fifo #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 4,
  parameter int DEPTH         = 16,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] C_DEPTH  = CW'(DEPTH);
  localparam logic [CW-1:0] C_AFULL  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] C_AEMPTY = CW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count_nxt;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_afull;
  logic                  r_aempty;
  logic                  r_ovf;
  logic                  r_unf;
  logic                  w_wr_acc;
  logic                  w_rd_acc;

  // Accept decisions use the registered flags only, so a write is never
  // allowed on a full FIFO (even with a read) and a read never on an empty one.
  always_comb begin
    w_wr_acc    = wr_en & ~r_full;
    w_rd_acc    = rd_en & ~r_empty;
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_wr_acc && w_rd_acc) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and flags, all derived from the next count value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= (C_AFULL == '0);
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == C_DEPTH);
      r_empty  <= (w_count_nxt == '0);
      r_afull  <= (w_count_nxt >= C_AFULL);
      r_aempty <= (w_count_nxt <= C_AEMPTY);
      // A new error in the same cycle as clr_err keeps the flag set.
      r_ovf    <= (wr_en & r_full)  | (r_ovf & ~clr_err);
      r_unf    <= (rd_en & r_empty) | (r_unf & ~clr_err);
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented straight from storage; forced to zero when empty.
    assign rd_data  = r_empty ? '0 : r_mem[r_rd_ptr];
    assign rd_valid = ~r_empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    // Registered read: data captured on the accepting edge, valid pulses once.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rd_data  <= '0;
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_rd_acc;
        if (w_rd_acc) r_rd_data <= r_mem[r_rd_ptr];
      end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
  end

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_argo_chan_fifo.sv
// Bench for argo_chan_fifo: one standard-mode and one FWFT instance share the
// same stimulus and are checked every cycle against a queue-based model, with
// directed literal expectations at key points of each scenario.
module tb_argo_chan_fifo;

  localparam int DW  = 8;
  localparam int AW  = 3;
  localparam int DEP = 8;
  localparam int AFT = 6;
  localparam int AET = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic          clr_err;

  logic [DW-1:0] s_rd_data, f_rd_data;
  logic          s_rd_valid, f_rd_valid;
  logic          s_full, f_full, s_empty, f_empty;
  logic          s_afull, f_afull, s_aempty, f_aempty;
  logic [AW:0]   s_count, f_count;
  logic          s_ovf, f_ovf, s_unf, f_unf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  argo_chan_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .FWFT(0),
                   .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_afull), .almost_empty(s_aempty), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf), .clr_err(clr_err));

  argo_chan_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .FWFT(1),
                   .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_afull), .almost_empty(f_aempty), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf), .clr_err(clr_err));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of stored words plus sticky error bits.
  logic [DW-1:0] mq[$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;
  logic          m_sv = 1'b0;
  logic [DW-1:0] m_sd = '0;
  bit            m_was_full;
  bit            m_was_empty;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_sv  = 1'b0;
      m_sd  = '0;
    end else begin
      m_was_full  = (mq.size() == DEP);
      m_was_empty = (mq.size() == 0);
      m_sv = rd_en && !m_was_empty;
      if (m_sv) m_sd = mq.pop_front();
      if (wr_en && !m_was_full) mq.push_back(wr_data);
      m_ovf = (wr_en && m_was_full) ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
      m_unf = (rd_en && m_was_empty) ? 1'b1 : (clr_err ? 1'b0 : m_unf);
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    int sz;
    sz = mq.size();
    chk("s_count", 32'(s_count), 32'(sz));
    chk("f_count", 32'(f_count), 32'(sz));
    chk("s_full",  32'(s_full),  32'(sz == DEP));
    chk("f_full",  32'(f_full),  32'(sz == DEP));
    chk("s_empty", 32'(s_empty), 32'(sz == 0));
    chk("f_empty", 32'(f_empty), 32'(sz == 0));
    chk("s_afull", 32'(s_afull), 32'(sz >= AFT));
    chk("f_afull", 32'(f_afull), 32'(sz >= AFT));
    chk("s_aempty", 32'(s_aempty), 32'(sz <= AET));
    chk("f_aempty", 32'(f_aempty), 32'(sz <= AET));
    chk("s_ovf", 32'(s_ovf), 32'(m_ovf));
    chk("f_ovf", 32'(f_ovf), 32'(m_ovf));
    chk("s_unf", 32'(s_unf), 32'(m_unf));
    chk("f_unf", 32'(f_unf), 32'(m_unf));
    chk("s_rd_valid", 32'(s_rd_valid), 32'(m_sv));
    chk("s_rd_data",  32'(s_rd_data),  32'(m_sd));
    chk("f_rd_valid", 32'(f_rd_valid), 32'(sz != 0));
    if (sz != 0) chk("f_rd_data", 32'(f_rd_data), 32'(mq[0]));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0; clr_err = 1'b0;
    repeat (2) cyc();
    chk("rst_count", 32'(s_count), 0);
    chk("rst_empty", 32'(s_empty), 1);
    chk("rst_full", 32'(s_full), 0);
    chk("rst_aempty", 32'(s_aempty), 1);
    chk("rst_afull", 32'(s_afull), 0);
    chk("rst_rd_valid", 32'(s_rd_valid), 0);
    chk("rst_rd_data", 32'(s_rd_data), 0);
    chk("rst_f_valid", 32'(f_rd_valid), 0);
    rst = 1'b0;

    // Reset asserted asynchronously in the middle of a 3-word burst.
    wr_en = 1'b1;
    wr_data = 8'h01; cyc();
    wr_data = 8'h02; cyc();
    chk("pre_rst_count", 32'(s_count), 2);
    wr_data = 8'h03;
    #2 rst = 1'b1;
    #1;
    chk("async_count", 32'(s_count), 0);
    chk("async_empty", 32'(s_empty), 1);
    chk("async_f_valid", 32'(f_rd_valid), 0);
    chk("async_f_count", 32'(f_count), 0);
    wr_en = 1'b0;
    cyc();
    rst = 1'b0;
    wr_en = 1'b1; wr_data = 8'h11; cyc();
    wr_en = 1'b0;
    chk("w11_count", 32'(s_count), 1);
    chk("w11_f_valid", 32'(f_rd_valid), 1);
    chk("w11_f_data", 32'(f_rd_data), 32'h11);
    rd_en = 1'b1; cyc();
    rd_en = 1'b0;
    chk("r11_valid", 32'(s_rd_valid), 1);
    chk("r11_data", 32'(s_rd_data), 32'h11);
    cyc();
    chk("r11_pulse", 32'(s_rd_valid), 0);
    chk("r11_hold", 32'(s_rd_data), 32'h11);

    // Fill with 0..8: ninth write overflows and is dropped.
    wr_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wr_data = DW'(i);
      cyc();
      if (i == 1) chk("thr_aempty_at2", 32'(s_aempty), 1);
      if (i == 2) chk("thr_aempty_at3", 32'(s_aempty), 0);
      if (i == 4) chk("thr_afull_at5", 32'(s_afull), 0);
      if (i == 5) chk("thr_afull_at6", 32'(s_afull), 1);
      if (i == 7) begin
        chk("fill_full", 32'(s_full), 1);
        chk("fill_count", 32'(s_count), 8);
        chk("fill_no_ovf", 32'(s_ovf), 0);
      end
    end
    wr_en = 1'b0;
    chk("ovf_set", 32'(s_ovf), 1);
    chk("ovf_count", 32'(s_count), 8);
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_f_data", 32'(f_rd_data), 32'(i));
      cyc();
      chk("drain_data", 32'(s_rd_data), 32'(i));
    end
    rd_en = 1'b0;
    chk("drain_empty", 32'(s_empty), 1);
    chk("drain_unf", 32'(s_unf), 0);
    clr_err = 1'b1; cyc(); clr_err = 1'b0;
    chk("ovf_cleared", 32'(s_ovf), 0);

    // Interleaved write/read pairs; pointers wrap more than twice.
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; wr_data = DW'(100 + i); cyc();
      wr_en = 1'b0;
      chk("wrap_cnt", 32'(s_count), 1);
      rd_en = 1'b1; cyc();
      rd_en = 1'b0;
      chk("wrap_data", 32'(s_rd_data), 32'(100 + i));
      chk("wrap_empty", 32'(s_empty), 1);
    end

    // Simultaneous read+write on full: read proceeds, write is lost.
    wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_data = DW'(200 + i); cyc();
    end
    rd_en = 1'b1; wr_data = 8'hEE; cyc();
    wr_en = 1'b0;
    chk("sim_full_count", 32'(s_count), 7);
    chk("sim_full_ovf", 32'(s_ovf), 1);
    chk("sim_full_data", 32'(s_rd_data), 200);
    for (int i = 1; i < 8; i++) begin
      cyc();
      chk("sim_drain", 32'(s_rd_data), 32'(200 + i));
    end
    // Simultaneous read+write on empty: write proceeds, read underflows.
    wr_en = 1'b1; wr_data = 8'h33; cyc();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("sim_empty_count", 32'(s_count), 1);
    chk("sim_empty_unf", 32'(s_unf), 1);
    clr_err = 1'b1; cyc(); clr_err = 1'b0;
    chk("clr_ovf", 32'(s_ovf), 0);
    chk("clr_unf", 32'(s_unf), 0);
    rd_en = 1'b1; cyc();
    chk("read_33", 32'(s_rd_data), 32'h33);
    clr_err = 1'b1; cyc();
    rd_en = 1'b0;
    chk("err_wins", 32'(s_unf), 1);
    cyc(); clr_err = 1'b0;
    chk("err_cleared", 32'(s_unf), 0);

    // FWFT head-word behaviour.
    wr_en = 1'b1; wr_data = 8'hA5; cyc();
    wr_en = 1'b0;
    chk("fwft_valid", 32'(f_rd_valid), 1);
    chk("fwft_a5", 32'(f_rd_data), 32'hA5);
    cyc();
    chk("fwft_stable", 32'(f_rd_data), 32'hA5);
    rd_en = 1'b1; cyc(); rd_en = 1'b0;
    chk("fwft_pop_empty", 32'(f_rd_valid), 0);
    wr_en = 1'b1; wr_data = 8'h5A; cyc();
    wr_data = 8'h3C; cyc();
    wr_en = 1'b0;
    chk("fwft_head1", 32'(f_rd_data), 32'h5A);
    rd_en = 1'b1; cyc(); rd_en = 1'b0;
    chk("fwft_head2", 32'(f_rd_data), 32'h3C);
    chk("fwft_valid2", 32'(f_rd_valid), 1);
    rd_en = 1'b1; cyc(); rd_en = 1'b0;
    chk("fwft_final_empty", 32'(f_empty), 1);
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/argo_chan_fifo.md
Name: argo_chan_fifo

Overview:
- Parametrised successor to the single-mode channel FIFO used for Argo pipes/channels.
- Synchronous single-clock FIFO with two selectable read modes: standard (registered read) and first-word-fall-through (FWFT).
- Adds an occupancy count, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags.
- Sits between the generated control-flow bits (writer and reader processes) and acts as the channel storage.

Parameters:
DATA_WIDTH, 32, width of each data word
ADDR_WIDTH, 4, pointer width; DEPTH must equal 1<<ADDR_WIDTH
DEPTH, 16, number of storage entries
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
AFULL_THRESH, DEPTH-2, almost_full asserted when count >= AFULL_THRESH
AEMPTY_THRESH, 2, almost_empty asserted when count <= AEMPTY_THRESH

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
wr_en  input  1  write request
wr_data  input  DATA_WIDTH  write data
rd_en  input  1  read (pop) request
rd_data  output  DATA_WIDTH  read data
rd_valid  output  1  rd_data holds a valid popped/head word
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AFULL_THRESH
almost_empty  output  1  count <= AEMPTY_THRESH
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty
clr_err  input  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (asynchronous, rst=1):
  - wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0.
  - empty=1, full=0, almost_empty=1, almost_full=(AFULL_THRESH==0), overflow=0, underflow=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data immediately; first edge after deassert behaves as from empty.
- Write accept: wr_en && !full at the edge -> mem[wr_ptr]<=wr_data; wr_ptr+1 mod DEPTH (natural wrap at ADDR_WIDTH bits).
- Read accept: rd_en && !empty at the edge -> rd_ptr+1 mod DEPTH.
- Status flags are sampled before the edge. Simultaneous rd_en on a full FIFO does NOT permit a write the same cycle; simultaneous wr_en on an empty FIFO does NOT permit a read the same cycle.
- Count: +1 on write-only accept, -1 on read-only accept, unchanged when both accept or neither.
- full, empty, almost_* and count are registered and consistent with count after each edge.
- Standard mode (FWFT=0):
  - Accepted read -> rd_data<=mem[rd_ptr] and rd_valid<=1 at the same edge; data is usable the cycle after rd_en.
  - rd_valid is a 1-cycle pulse per accepted read; rd_data holds its value otherwise.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr] (combinational from storage), rd_valid = !empty.
  - rd_en acknowledges and pops the head word; the next word appears after the edge.
  - A written word is visible one cycle after its write edge.
- Errors:
  - wr_en && full -> overflow<=1; write dropped; state otherwise unchanged.
  - rd_en && empty -> underflow<=1; no pointer or data change.
  - Both flags are sticky until clr_err=1 at an edge. If a new error and clr_err occur in the same cycle, the new error wins (flag stays 1).
- Threshold edge cases: AEMPTY_THRESH=0 -> almost_empty==empty; AFULL_THRESH=DEPTH -> almost_full==full.
- No combinational path from wr_en/rd_en to full/empty/count.

Test Plan:
- Reset/defaults (ADDR_WIDTH=3, DEPTH=8): assert rst mid-write of 3 words -> count=0, empty=1, rd_valid=0 asynchronously; next write of 0x11 then read returns 0x11.
- Fill/overflow: write 0..8 (9 writes) with no reads -> full=1 after 8th edge, count=8, overflow=1, 9th word dropped; reading 8 words returns 0..7 in order, then empty=1.
- Wrap-around: 20 interleaved write/read pairs with values 100..119 -> every read returns the matching value; count never exceeds 1; pointers wrap twice.
- Simultaneous events: at count=8, rd_en=wr_en=1 -> count=7, overflow=1, written word lost. At count=0, both asserted -> count=1, underflow=1. Then clr_err=1 -> both flags 0.
- Thresholds (AFULL_THRESH=6, AEMPTY_THRESH=2): almost_empty deasserts on the edge where count goes 2->3; almost_full asserts where count goes 5->6.
- FWFT=1: write 0xA5 -> next cycle rd_valid=1, rd_data=0xA5 with rd_en low; pulse rd_en -> rd_valid=0 if no other data; with two words queued, rd_data changes to the second word on the edge of the pop.
